// File: rtl/alu_ex_stage_if.sv
// Signal bundle between the execute stage, the decode stage, the external ALU and the memory stage.
// The master side is the environment around the stage; the slave side is alu_ex_stage itself.
interface alu_ex_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
);
  logic             flush_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] rs1_val_i;
  logic [WIDTH-1:0] rs2_val_i;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] pc_i;
  logic             srca_sel_i;
  logic             srcb_sel_i;
  logic [2:0]       alucontrol_i;
  logic [RADDR-1:0] rs1_i;
  logic [RADDR-1:0] rs2_i;
  logic [RADDR-1:0] rd_i;
  logic             regwrite_i;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic [RADDR-1:0] rd_o;
  logic             regwrite_o;

  modport master (
    output flush_i, in_valid_i, rs1_val_i, rs2_val_i, imm_i, pc_i, srca_sel_i, srcb_sel_i,
           alucontrol_i, rs1_i, rs2_i, rd_i, regwrite_i, alu_result_i, alu_zero_i, out_ready_i,
    input  in_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, out_valid_o, result_o, zero_o, rd_o,
           regwrite_o
  );

  modport slave (
    input  flush_i, in_valid_i, rs1_val_i, rs2_val_i, imm_i, pc_i, srca_sel_i, srcb_sel_i,
           alucontrol_i, rs1_i, rs2_i, rd_i, regwrite_i, alu_result_i, alu_zero_i, out_ready_i,
    output in_ready_o, alu_a_o, alu_b_o, alu_ctrl_o, out_valid_o, result_o, zero_o, rd_o,
           regwrite_o
  );
endinterface

// File: rtl/alu_ex_stage.sv
// Execute stage around an external combinational ALU: ID/EX slot feeds the ALU, EX/MEM slot holds
// its result; valid/ready on both sides. Define ALU_EX_FWD_EN for the EX/MEM-to-EX bypass.
module alu_ex_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input logic          clk_i,
  input logic          rst_i,
  alu_ex_stage_if.slave bus
);
  // ID/EX slot
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       ctrl_q;
  logic [RADDR-1:0] rs1_q, rs2_q, rd1_q;
  logic             regwrite1_q, a_reg_q, b_reg_q;
  // EX/MEM slot
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [RADDR-1:0] rd2_q;
  logic             regwrite2_q;

  logic adv1, adv2, s2_free, in_ready, accept;

  always_comb begin
    adv2     = v2_q & bus.out_ready_i;
    s2_free  = ~v2_q | adv2;
    adv1     = v1_q & s2_free;
    in_ready = ~v1_q | adv1;
    accept   = bus.in_valid_i & in_ready;

    v1_d = v1_q;
    v2_d = v2_q;
    if (accept) begin
      v1_d = 1'b1;
    end else if (adv1) begin
      v1_d = 1'b0;
    end
    if (adv1) begin
      v2_d = 1'b1;
    end else if (adv2) begin
      v2_d = 1'b0;
    end
    if (bus.flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd1_q       <= '0;
      regwrite1_q <= 1'b0;
      a_reg_q     <= 1'b0;
      b_reg_q     <= 1'b0;
    end else if (accept && !bus.flush_i) begin
      a_q         <= bus.srca_sel_i ? bus.pc_i : bus.rs1_val_i;
      b_q         <= bus.srcb_sel_i ? bus.imm_i : bus.rs2_val_i;
      ctrl_q      <= bus.alucontrol_i;
      rs1_q       <= bus.rs1_i;
      rs2_q       <= bus.rs2_i;
      rd1_q       <= bus.rd_i;
      regwrite1_q <= bus.regwrite_i;
      a_reg_q     <= ~bus.srca_sel_i;
      b_reg_q     <= ~bus.srcb_sel_i;
    end
  end

  // Writes to x0 are dropped here so regwrite_o can be used directly by forwarding and writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd2_q       <= '0;
      regwrite2_q <= 1'b0;
    end else if (adv1 && !bus.flush_i) begin
      result_q    <= bus.alu_result_i;
      zero_q      <= bus.alu_zero_i;
      rd2_q       <= rd1_q;
      regwrite2_q <= regwrite1_q & (rd1_q != '0);
    end
  end

`ifdef ALU_EX_FWD_EN
  logic fwd_ok;
  always_comb begin
    fwd_ok      = v2_q & regwrite2_q & (rd2_q != '0);
    bus.alu_a_o = (fwd_ok && a_reg_q && (rd2_q == rs1_q)) ? result_q : a_q;
    bus.alu_b_o = (fwd_ok && b_reg_q && (rd2_q == rs2_q)) ? result_q : b_q;
  end
`else
  logic unused_fwd;
  assign unused_fwd  = ^{rs1_q, rs2_q, a_reg_q, b_reg_q};
  assign bus.alu_a_o = a_q;
  assign bus.alu_b_o = b_q;
`endif

  assign bus.alu_ctrl_o  = ctrl_q;
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = v2_q;
  assign bus.result_o    = result_q;
  assign bus.zero_o      = zero_q;
  assign bus.rd_o        = rd2_q;
  assign bus.regwrite_o  = regwrite2_q;
endmodule
